// File: rtl/rc4_key_search_control.sv
// RC4 key search sequencer: walks a key range, driving init/shuffle/decrypt
// engines per key until a valid message, range exhaustion, timeout or abort.
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   start, abort         begin search / cancel search
//   init_finish          init engine done
//   shuffle_finish       shuffle engine done
//   decrypt_finish       decrypt engine done
//   msg_valid            decrypt result check (with decrypt_finish)
//   start_init           1-cycle start pulse to init engine
//   start_shuffle        1-cycle start pulse to shuffle engine
//   start_decrypt        1-cycle start pulse to decrypt engine
//   key                  current candidate key
//   busy                 search in progress
//   done                 1-cycle pulse on entry to a terminal state
//   found                key holds the valid key
//   exhausted            range finished without a valid key
//   timeout_err          a stage exceeded TIMEOUT_CYCLES
module rc4_key_search_control #(
  parameter int unsigned KEY_WIDTH      = 24,
  parameter int unsigned KEY_START      = 0,
  parameter int unsigned KEY_LAST       = 2**KEY_WIDTH-1,
  parameter int unsigned KEY_STRIDE     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 init_finish,
  input  logic                 shuffle_finish,
  input  logic                 decrypt_finish,
  input  logic                 msg_valid,
  output logic                 start_init,
  output logic                 start_shuffle,
  output logic                 start_decrypt,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 exhausted,
  output logic                 timeout_err
);

  localparam int WD_W =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  // The counter holds the number of WAIT cycles already spent, so the
  // stage expires in the cycle where it equals TIMEOUT_CYCLES-1.
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  localparam logic [KEY_WIDTH-1:0] KEY_INIT = KEY_WIDTH'(KEY_START);
  localparam logic [KEY_WIDTH:0]   STRIDE_X = (KEY_WIDTH+1)'(KEY_STRIDE);
  localparam logic [KEY_WIDTH:0]   LAST_X   = (KEY_WIDTH+1)'(KEY_LAST);

  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_START_INIT    = 4'd1,
    S_WAIT_INIT     = 4'd2,
    S_START_SHUFFLE = 4'd3,
    S_WAIT_SHUFFLE  = 4'd4,
    S_START_DECRYPT = 4'd5,
    S_WAIT_DECRYPT  = 4'd6,
    S_NEXT_KEY      = 4'd7,
    S_FOUND         = 4'd8,
    S_EXHAUSTED     = 4'd9,
    S_ERROR         = 4'd10
  } state_t;

  state_t                 state;
  state_t                 nxt;
  logic [KEY_WIDTH-1:0]   key_nxt;
  logic [KEY_WIDTH:0]     sum;
  logic [WD_W-1:0]        wd;
  logic [WD_W-1:0]        wd_nxt;
  logic                   expire;
  logic                   in_wait;

  always_comb begin
    nxt     = state;
    key_nxt = key;
    sum     = {1'b0, key} + STRIDE_X;
    expire  = (TIMEOUT_CYCLES != 0) && (wd == WD_LAST);
    in_wait = state inside {S_WAIT_INIT, S_WAIT_SHUFFLE, S_WAIT_DECRYPT};

    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR: begin
          if (start) begin
            nxt     = S_START_INIT;
            key_nxt = KEY_INIT;
          end
        end
        S_START_INIT:    nxt = S_WAIT_INIT;
        S_WAIT_INIT: begin
          if (init_finish)  nxt = S_START_SHUFFLE;
          else if (expire)  nxt = S_ERROR;
        end
        S_START_SHUFFLE: nxt = S_WAIT_SHUFFLE;
        S_WAIT_SHUFFLE: begin
          if (shuffle_finish) nxt = S_START_DECRYPT;
          else if (expire)    nxt = S_ERROR;
        end
        S_START_DECRYPT: nxt = S_WAIT_DECRYPT;
        S_WAIT_DECRYPT: begin
          if (decrypt_finish)
            nxt = msg_valid ? S_FOUND : S_NEXT_KEY;
          else if (expire)
            nxt = S_ERROR;
        end
        S_NEXT_KEY: begin
          // Carry out of KEY_WIDTH means the stride wrapped the key.
          if (sum[KEY_WIDTH] || (sum > LAST_X)) begin
            nxt = S_EXHAUSTED;
          end else begin
            nxt     = S_START_INIT;
            key_nxt = sum[KEY_WIDTH-1:0];
          end
        end
        default: nxt = S_IDLE;
      endcase
    end

    wd_nxt = (in_wait && (nxt == state)) ? wd + WD_W'(1) : '0;
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      key           <= KEY_INIT;
      wd            <= '0;
      start_init    <= 1'b0;
      start_shuffle <= 1'b0;
      start_decrypt <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      exhausted     <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= nxt;
      key           <= key_nxt;
      wd            <= wd_nxt;
      start_init    <= (nxt == S_START_INIT);
      start_shuffle <= (nxt == S_START_SHUFFLE);
      start_decrypt <= (nxt == S_START_DECRYPT);
      busy          <= !(nxt inside
                         {S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR});
      done          <= (nxt != state) &&
                       (nxt inside {S_FOUND, S_EXHAUSTED, S_ERROR});
      found         <= (nxt == S_FOUND);
      exhausted     <= (nxt == S_EXHAUSTED);
      timeout_err   <= (nxt == S_ERROR);
    end
  end

endmodule
